// File: rtl/ahb_bus_matrix_output_stage_rr.sv
// Slave-side output stage of the AHB bus matrix: round-robin arbitration
// between two matrix input ports with burst hold and grant parking, plus the
// address-phase and data-phase multiplexers onto a single slave port.
module ahb_bus_matrix_output_stage_rr #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned RST_GRANT = 0
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  // Input stage 0
  input  logic          sel_op0,
  input  logic [AW-1:0] addr_op0,
  input  logic [1:0]    trans_op0,
  input  logic          write_op0,
  input  logic [2:0]    size_op0,
  input  logic [2:0]    burst_op0,
  input  logic [3:0]    prot_op0,
  input  logic [DW-1:0] wdata_op0,
  // Input stage 1
  input  logic          sel_op1,
  input  logic [AW-1:0] addr_op1,
  input  logic [1:0]    trans_op1,
  input  logic          write_op1,
  input  logic [2:0]    size_op1,
  input  logic [2:0]    burst_op1,
  input  logic [3:0]    prot_op1,
  input  logic [DW-1:0] wdata_op1,
  // Grant feedback to the decoders
  output logic          active_op0,
  output logic          active_op1,
  // Slave port MI
  output logic          HSELM,
  output logic [AW-1:0] HADDRM,
  output logic [1:0]    HTRANSM,
  output logic          HWRITEM,
  output logic [2:0]    HSIZEM,
  output logic [2:0]    HBURSTM,
  output logic [3:0]    HPROTM,
  output logic [DW-1:0] HWDATAM,
  output logic          HREADYMUXM,
  input  logic          HREADYOUTM
);

  localparam logic [1:0] TransIdle = 2'b00;
  localparam logic [1:0] TransBusy = 2'b01;
  localparam logic [1:0] TransSeq  = 2'b11;

  // Address-phase owner and data-phase owner
  logic grant_q, grant_d;
  logic data_port_q;

  logic       req0, req1;
  logic       grant_sel;
  logic [1:0] grant_trans;
  logic       hold;

  // Request and burst-hold decode
  always_comb begin
    req0        = sel_op0 & trans_op0[1];
    req1        = sel_op1 & trans_op1[1];
    grant_sel   = grant_q ? sel_op1 : sel_op0;
    grant_trans = grant_q ? trans_op1 : trans_op0;
    // SEQ/BUSY from the current owner keeps the burst together
    hold        = grant_sel & ((grant_trans == TransSeq) | (grant_trans == TransBusy));
  end

  // Next-grant: hold, then round-robin on contention, then single requester, else park
  always_comb begin
    grant_d = grant_q;
    if (hold) begin
      grant_d = grant_q;
    end else if (req0 && req1) begin
      grant_d = ~grant_q;
    end else if (req0) begin
      grant_d = 1'b0;
    end else if (req1) begin
      grant_d = 1'b1;
    end
  end

  // Ownership registers advance only on an accepted (ready) cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q     <= 1'(RST_GRANT);
      data_port_q <= 1'b0;
    end else if (HREADYOUTM) begin
      grant_q     <= grant_d;
      data_port_q <= grant_q;
    end
  end

  // Address-phase mux by grant; unselected owner presents IDLE
  always_comb begin
    HSELM   = grant_sel;
    HTRANSM = grant_sel ? grant_trans : TransIdle;
    if (grant_q) begin
      HADDRM  = addr_op1;
      HWRITEM = write_op1;
      HSIZEM  = size_op1;
      HBURSTM = burst_op1;
      HPROTM  = prot_op1;
    end else begin
      HADDRM  = addr_op0;
      HWRITEM = write_op0;
      HSIZEM  = size_op0;
      HBURSTM = burst_op0;
      HPROTM  = prot_op0;
    end
  end

  // Data-phase mux, ready pass-through and grant feedback
  always_comb begin
    HWDATAM    = data_port_q ? wdata_op1 : wdata_op0;
    HREADYMUXM = HREADYOUTM;
    active_op0 = ~grant_q & sel_op0;
    active_op1 = grant_q & sel_op1;
  end

endmodule

// File: tb/tb_ahb_bus_matrix_output_stage_rr.sv
// Self-checking bench for the AHB output stage: per-cycle stimulus rows carry
// the expected address owner and data owner; expected MI values are queued
// when a row is driven and compared at the following falling edge.
module tb_ahb_bus_matrix_output_stage_rr;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BZ = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR4  = 3'b011;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        sel_op0, sel_op1;
  logic [31:0] addr_op0, addr_op1;
  logic [1:0]  trans_op0, trans_op1;
  logic        write_op0, write_op1;
  logic [2:0]  size_op0, size_op1;
  logic [2:0]  burst_op0, burst_op1;
  logic [3:0]  prot_op0, prot_op1;
  logic [31:0] wdata_op0, wdata_op1;
  logic        active_op0, active_op1;
  logic        HSELM;
  logic [31:0] HADDRM;
  logic [1:0]  HTRANSM;
  logic        HWRITEM;
  logic [2:0]  HSIZEM;
  logic [2:0]  HBURSTM;
  logic [3:0]  HPROTM;
  logic [31:0] HWDATAM;
  logic        HREADYMUXM;
  logic        HREADYOUTM;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [31:0] wdata;
    logic        rdymux;
    logic        act0;
    logic        act1;
  } mi_t;

  typedef struct {
    logic        rdy;
    logic        s0;
    logic [1:0]  t0;
    logic [31:0] a0;
    logic [2:0]  b0;
    logic [31:0] d0;
    logic        s1;
    logic [1:0]  t1;
    logic [31:0] a1;
    logic [2:0]  b1;
    logic [31:0] d1;
    logic        eg;
    logic        edp;
  } stim_t;

  int  checks = 0;
  int  passed = 0;
  mi_t exp_q[$];

  ahb_bus_matrix_output_stage_rr #(
    .AW(32),
    .DW(32),
    .RST_GRANT(0)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .sel_op0(sel_op0),
    .addr_op0(addr_op0),
    .trans_op0(trans_op0),
    .write_op0(write_op0),
    .size_op0(size_op0),
    .burst_op0(burst_op0),
    .prot_op0(prot_op0),
    .wdata_op0(wdata_op0),
    .sel_op1(sel_op1),
    .addr_op1(addr_op1),
    .trans_op1(trans_op1),
    .write_op1(write_op1),
    .size_op1(size_op1),
    .burst_op1(burst_op1),
    .prot_op1(prot_op1),
    .wdata_op1(wdata_op1),
    .active_op0(active_op0),
    .active_op1(active_op1),
    .HSELM(HSELM),
    .HADDRM(HADDRM),
    .HTRANSM(HTRANSM),
    .HWRITEM(HWRITEM),
    .HSIZEM(HSIZEM),
    .HBURSTM(HBURSTM),
    .HPROTM(HPROTM),
    .HWDATAM(HWDATAM),
    .HREADYMUXM(HREADYMUXM),
    .HREADYOUTM(HREADYOUTM)
  );

  always #5 HCLK = ~HCLK;

  function automatic stim_t row(input logic rdy,
                                input logic s0, input logic [1:0] t0, input logic [31:0] a0,
                                input logic [2:0] b0, input logic [31:0] d0,
                                input logic s1, input logic [1:0] t1, input logic [31:0] a1,
                                input logic [2:0] b1, input logic [31:0] d1,
                                input logic eg, input logic edp);
    stim_t s;
    s.rdy = rdy;
    s.s0 = s0; s.t0 = t0; s.a0 = a0; s.b0 = b0; s.d0 = d0;
    s.s1 = s1; s.t1 = t1; s.a1 = a1; s.b1 = b1; s.d1 = d1;
    s.eg = eg; s.edp = edp;
    return s;
  endfunction

  // Port 0 writes with word size, port 1 reads with halfword size
  task automatic apply(input stim_t s);
    HREADYOUTM = s.rdy;
    sel_op0 = s.s0; trans_op0 = s.t0; addr_op0 = s.a0; burst_op0 = s.b0; wdata_op0 = s.d0;
    sel_op1 = s.s1; trans_op1 = s.t1; addr_op1 = s.a1; burst_op1 = s.b1; wdata_op1 = s.d1;
    write_op0 = 1'b1; size_op0 = 3'd2; prot_op0 = 4'h3;
    write_op1 = 1'b0; size_op1 = 3'd1; prot_op1 = 4'ha;
  endtask

  // Expected MI view given which port owns the address and data phases
  function automatic mi_t exp_mi(input logic g, input logic dp);
    mi_t e;
    e.sel    = g ? sel_op1 : sel_op0;
    e.trans  = e.sel ? (g ? trans_op1 : trans_op0) : 2'b00;
    e.addr   = g ? addr_op1 : addr_op0;
    e.write  = g ? write_op1 : write_op0;
    e.size   = g ? size_op1 : size_op0;
    e.burst  = g ? burst_op1 : burst_op0;
    e.prot   = g ? prot_op1 : prot_op0;
    e.wdata  = dp ? wdata_op1 : wdata_op0;
    e.rdymux = HREADYOUTM;
    e.act0   = !g && sel_op0;
    e.act1   = g && sel_op1;
    return e;
  endfunction

  function automatic mi_t cur_mi();
    mi_t o;
    o.sel = HSELM; o.trans = HTRANSM; o.addr = HADDRM; o.write = HWRITEM;
    o.size = HSIZEM; o.burst = HBURSTM; o.prot = HPROTM; o.wdata = HWDATAM;
    o.rdymux = HREADYMUXM; o.act0 = active_op0; o.act1 = active_op1;
    return o;
  endfunction

  task automatic do_reset();
    apply(row(1'b1, 0, ID, 0, SINGLE, 0, 0, ID, 0, SINGLE, 0, 0, 0));
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    mi_t obs, e;
    apply(row(1'b0, 0, ID, 0, SINGLE, 0, 0, ID, 0, SINGLE, 0, 0, 0));
    write_op0 = 1'b0; size_op0 = 3'd0; prot_op0 = 4'h0;
    write_op1 = 1'b0; size_op1 = 3'd0; prot_op1 = 4'h0;
    HRESETn = 1'b0;
    exp_q.push_back('0);
    #1;
    obs = cur_mi(); e = exp_q.pop_front(); checks++;
    if (obs !== e) $display("FAIL reset_asserted: MI got %h, expected %h", obs, e);
    else passed++;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    exp_q.push_back('0);
    @(negedge HCLK);
    obs = cur_mi(); e = exp_q.pop_front(); checks++;
    if (obs !== e) $display("FAIL reset_released_idle: MI got %h, expected %h", obs, e);
    else passed++;
    @(posedge HCLK); #1;
  endtask

  task automatic test_latency();
    stim_t rows[$];
    mi_t obs, e;
    do_reset();
    rows.push_back(row(1, 0, ID, 0, SINGLE, 0, 1, NS, 32'h1000_0000, SINGLE, 0, 0, 0));
    rows.push_back(row(1, 0, ID, 0, SINGLE, 0, 1, NS, 32'h1000_0000, SINGLE, 0, 1, 0));
    rows.push_back(row(1, 0, ID, 0, SINGLE, 0, 1, ID, 32'h1000_0000, SINGLE, 32'hd1d1_0001, 1, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(exp_mi(rows[i].eg, rows[i].edp));
      @(negedge HCLK);
      obs = cur_mi(); e = exp_q.pop_front(); checks++;
      if (obs !== e) $display("FAIL latency[%0d]: MI got %h, expected %h", i, obs, e);
      else passed++;
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_round_robin();
    mi_t obs, e;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      apply(row(1, 1, NS, 32'h2000_0000 + 32'(k * 4), SINGLE, 32'ha000_0000 + 32'(k),
                1, NS, 32'h2100_0000 + 32'(k * 4), SINGLE, 32'hb000_0000 + 32'(k),
                logic'(k % 2), (k == 0) ? 1'b0 : logic'((k - 1) % 2)));
      exp_q.push_back(exp_mi(logic'(k % 2), (k == 0) ? 1'b0 : logic'((k - 1) % 2)));
      @(negedge HCLK);
      obs = cur_mi(); e = exp_q.pop_front(); checks++;
      if (obs !== e) $display("FAIL round_robin[%0d]: MI got %h, expected %h", k, obs, e);
      else passed++;
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_burst_hold();
    stim_t rows[$];
    mi_t obs, e;
    do_reset();
    rows.push_back(row(1, 1, NS, 32'h3000_0000, INCR4, 0, 0, ID, 0, SINGLE, 0, 0, 0));
    rows.push_back(row(1, 1, SQ, 32'h3000_0004, INCR4, 32'hda00_0000, 1, NS, 32'h3100_0000, SINGLE, 0, 0, 0));
    rows.push_back(row(1, 1, BZ, 32'h3000_0008, INCR4, 32'hda00_0001, 1, NS, 32'h3100_0000, SINGLE, 0, 0, 0));
    rows.push_back(row(1, 1, SQ, 32'h3000_0008, INCR4, 32'hda00_0001, 1, NS, 32'h3100_0000, SINGLE, 0, 0, 0));
    rows.push_back(row(1, 1, SQ, 32'h3000_000c, INCR4, 32'hda00_0002, 1, NS, 32'h3100_0000, SINGLE, 0, 0, 0));
    rows.push_back(row(1, 0, ID, 0, SINGLE, 32'hda00_0003, 1, NS, 32'h3100_0000, SINGLE, 0, 0, 0));
    rows.push_back(row(1, 0, ID, 0, SINGLE, 0, 1, NS, 32'h3100_0000, SINGLE, 0, 1, 0));
    rows.push_back(row(1, 0, ID, 0, SINGLE, 0, 1, ID, 32'h3100_0000, SINGLE, 32'hdb00_0000, 1, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(exp_mi(rows[i].eg, rows[i].edp));
      @(negedge HCLK);
      obs = cur_mi(); e = exp_q.pop_front(); checks++;
      if (obs !== e) $display("FAIL burst_hold[%0d]: MI got %h, expected %h", i, obs, e);
      else passed++;
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_wait_states();
    stim_t rows[$];
    mi_t obs, e;
    do_reset();
    rows.push_back(row(1, 0, ID, 0, SINGLE, 0, 1, NS, 32'h4100_0000, SINGLE, 0, 0, 0));
    rows.push_back(row(1, 1, NS, 32'h4000_0000, SINGLE, 0, 1, ID, 32'h4100_0000, SINGLE, 32'hdb44_0000, 1, 0));
    rows.push_back(row(0, 1, NS, 32'h4000_0000, SINGLE, 0, 1, ID, 32'h4100_0000, SINGLE, 32'hdb44_0000, 0, 1));
    rows.push_back(row(1, 1, NS, 32'h4000_0000, SINGLE, 0, 1, ID, 32'h4100_0000, SINGLE, 32'hdb44_0000, 0, 1));
    for (int k = 0; k < 3; k++)
      rows.push_back(row(0, 1, ID, 32'h4000_0000, SINGLE, 32'hda44_0000, 1, NS, 32'h4200_0000, SINGLE, 0, 0, 0));
    rows.push_back(row(1, 1, ID, 32'h4000_0000, SINGLE, 32'hda44_0000, 1, NS, 32'h4200_0000, SINGLE, 0, 0, 0));
    rows.push_back(row(1, 0, ID, 0, SINGLE, 0, 1, NS, 32'h4200_0000, SINGLE, 0, 1, 0));
    rows.push_back(row(1, 0, ID, 0, SINGLE, 0, 1, ID, 32'h4200_0000, SINGLE, 32'hdc44_0000, 1, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(exp_mi(rows[i].eg, rows[i].edp));
      @(negedge HCLK);
      obs = cur_mi(); e = exp_q.pop_front(); checks++;
      if (obs !== e) $display("FAIL wait_states[%0d]: MI got %h, expected %h", i, obs, e);
      else passed++;
      @(posedge HCLK); #1;
    end
  endtask

  // Continues from the S1 transfer that ends the wait-state scenario
  task automatic test_park();
    stim_t rows[$];
    mi_t obs, e;
    rows.push_back(row(1, 0, ID, 0, SINGLE, 0, 0, ID, 0, SINGLE, 0, 1, 1));
    rows.push_back(row(1, 0, ID, 0, SINGLE, 0, 1, NS, 32'h5000_0000, SINGLE, 0, 1, 1));
    rows.push_back(row(1, 0, ID, 0, SINGLE, 0, 1, ID, 32'h5000_0000, SINGLE, 32'hdd55_0000, 1, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(exp_mi(rows[i].eg, rows[i].edp));
      @(negedge HCLK);
      obs = cur_mi(); e = exp_q.pop_front(); checks++;
      if (obs !== e) $display("FAIL park[%0d]: MI got %h, expected %h", i, obs, e);
      else passed++;
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_reset_mid_burst();
    stim_t rows[$];
    stim_t rec[$];
    mi_t obs, e;
    do_reset();
    rows.push_back(row(1, 0, ID, 0, SINGLE, 0, 1, NS, 32'h6100_0000, INCR4, 0, 0, 0));
    rows.push_back(row(1, 1, NS, 32'h6000_0000, SINGLE, 0, 1, SQ, 32'h6100_0004, INCR4, 32'hdb66_0000, 1, 0));
    rows.push_back(row(1, 1, NS, 32'h6000_0000, SINGLE, 32'hda66_0000, 1, SQ, 32'h6100_0008, INCR4, 32'hdb66_0001, 1, 1));
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(exp_mi(rows[i].eg, rows[i].edp));
      @(negedge HCLK);
      obs = cur_mi(); e = exp_q.pop_front(); checks++;
      if (obs !== e) $display("FAIL mid_burst[%0d]: MI got %h, expected %h", i, obs, e);
      else passed++;
      @(posedge HCLK); #1;
    end
    // Reset lands between edges with both ports still driving
    HRESETn = 1'b0;
    exp_q.push_back(exp_mi(1'b0, 1'b0));
    #1;
    obs = cur_mi(); e = exp_q.pop_front(); checks++;
    if (obs !== e) $display("FAIL async_reset_grant: MI got %h, expected %h", obs, e);
    else passed++;
    sel_op0 = 1'b0;
    exp_q.push_back(exp_mi(1'b0, 1'b0));
    #1;
    obs = cur_mi(); e = exp_q.pop_front(); checks++;
    if (obs !== e) $display("FAIL async_reset_hsel: MI got %h, expected %h", obs, e);
    else passed++;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    rec.push_back(row(1, 1, NS, 32'h6000_0000, SINGLE, 0, 1, NS, 32'h6100_0000, SINGLE, 0, 0, 0));
    rec.push_back(row(1, 1, NS, 32'h6000_0000, SINGLE, 0, 1, ID, 32'h6100_0000, SINGLE, 32'hdb66_0002, 1, 0));
    rec.push_back(row(1, 0, ID, 0, SINGLE, 32'hda66_0003, 0, ID, 0, SINGLE, 32'hdb66_0003, 0, 1));
    foreach (rec[i]) begin
      apply(rec[i]);
      exp_q.push_back(exp_mi(rec[i].eg, rec[i].edp));
      @(negedge HCLK);
      obs = cur_mi(); e = exp_q.pop_front(); checks++;
      if (obs !== e) $display("FAIL recovery[%0d]: MI got %h, expected %h", i, obs, e);
      else passed++;
      @(posedge HCLK); #1;
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    apply(row(1'b0, 0, ID, 0, SINGLE, 0, 0, ID, 0, SINGLE, 0, 0, 0));
    test_reset();
    test_latency();
    test_round_robin();
    test_burst_hold();
    test_wait_states();
    test_park();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
